// File: rtl/pong_pkg.sv
// Shared Pong constants: screen and ball geometry, racket dimensions, default serve
// position and the game flow FSM state encoding.
package pong_pkg;

   localparam int unsigned ScreenW       = 640;
   localparam int unsigned ScreenH       = 480;
   localparam int unsigned BallSize      = 16;
   // Largest legal top-left corner so the whole ball stays on screen.
   localparam int unsigned BallMaxX      = ScreenW - BallSize;
   localparam int unsigned BallMaxY      = ScreenH - BallSize;

   localparam int unsigned RacketW       = 8;
   localparam int unsigned RacketH       = 64;
   localparam int unsigned RacketLeftX   = 16;
   localparam int unsigned RacketRightX  = ScreenW - RacketLeftX - RacketW;

   localparam int unsigned DefBallStartX = 312;
   localparam int unsigned DefBallStartY = 232;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StServe = 3'd1,
      StPlay  = 3'd2,
      StPoint = 3'd3,
      StOver  = 3'd4
   } game_state_e;

endpackage

// File: rtl/score_counter.sv
// Saturating 4-bit score counter: clear wins over increment, increments stop at MaxCount.
module score_counter #(
   parameter int unsigned MaxCount = 9
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       inc_i,
   input  logic       clr_i,
   output logic [3:0] count_o,
   output logic       at_max_o
);

   logic [3:0] count_q, count_d;

   assign at_max_o = (count_q == 4'(MaxCount));
   assign count_o  = count_q;

   // Next count: clear, saturating increment, or hold.
   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (inc_i && !at_max_o) begin
         count_d = count_q + 4'd1;
      end
   end

   // Count register with asynchronous active-high reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/game_flow_controller.sv
// Pong game flow: serve delay, ball movement with screen clamping, scoring and game over.
// Optional build macro PONG_PAUSE_EN adds a pause input that freezes frame-tick driven
// progress in SERVE and PLAY while still letting point pulses act.
module game_flow_controller import pong_pkg::*; #(
   parameter int unsigned BALL_START_X = DefBallStartX,
   parameter int unsigned BALL_START_Y = DefBallStartY,
   parameter int unsigned SERVE_FRAMES = 60,
   parameter int unsigned WIN_SCORE    = 9
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic       start,
   input  logic       point_left,
   input  logic       point_right,
   input  logic       ball_dir_x,
   input  logic       ball_dir_y,
   output logic [9:0] ball_x,
   output logic [9:0] ball_y,
   output logic [3:0] score_left,
   output logic [3:0] score_right,
   output logic       game_over,
   output logic       winner,
   output logic       playing
`ifdef PONG_PAUSE_EN
   ,
   input  logic       pause
`endif
);

   localparam logic [9:0]  StartX    = 10'(BALL_START_X);
   localparam logic [9:0]  StartY    = 10'(BALL_START_Y);
   localparam logic [9:0]  MaxX      = 10'(BallMaxX);
   localparam logic [9:0]  MaxY      = 10'(BallMaxY);
   localparam logic [15:0] ServeLast = 16'(SERVE_FRAMES - 1);
   localparam logic [3:0]  WinM1     = 4'(WIN_SCORE - 1);

   game_state_e state_q, state_d;
   logic [9:0]  ball_x_q, ball_x_d, ball_y_q, ball_y_d;
   logic [15:0] serve_cnt_q, serve_cnt_d;
   logic        scorer_left_q, scorer_left_d;
   logic        winner_q, winner_d;
   logic        inc_left, inc_right, clr_scores;
   logic        left_at_max, right_at_max;
   logic        pause_eff, tick_en;

`ifdef PONG_PAUSE_EN
   assign pause_eff = pause;
`else
   assign pause_eff = 1'b0;
`endif
   assign tick_en = frame_tick & ~pause_eff;

   score_counter #(.MaxCount(WIN_SCORE)) u_score_left (
      .clk      (clk),
      .reset    (reset),
      .inc_i    (inc_left),
      .clr_i    (clr_scores),
      .count_o  (score_left),
      .at_max_o (left_at_max)
   );

   score_counter #(.MaxCount(WIN_SCORE)) u_score_right (
      .clk      (clk),
      .reset    (reset),
      .inc_i    (inc_right),
      .clr_i    (clr_scores),
      .count_o  (score_right),
      .at_max_o (right_at_max)
   );

   // Next-state, ball movement and score control. The ball sits at the start position in
   // every state except PLAY; the serve counter is zero outside SERVE, which clears it on entry.
   always_comb begin
      state_d       = state_q;
      ball_x_d      = StartX;
      ball_y_d      = StartY;
      serve_cnt_d   = '0;
      scorer_left_d = scorer_left_q;
      winner_d      = winner_q;
      inc_left      = 1'b0;
      inc_right     = 1'b0;
      clr_scores    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) state_d = StServe;
         end
         StServe: begin
            serve_cnt_d = serve_cnt_q;
            if (tick_en) begin
               if (serve_cnt_q >= ServeLast) state_d = StPlay;
               else serve_cnt_d = serve_cnt_q + 16'd1;
            end
         end
         StPlay: begin
            ball_x_d = ball_x_q;
            ball_y_d = ball_y_q;
            if (point_left || point_right) begin
               // Simultaneous pulses credit the left player; this cycle's tick is dropped.
               scorer_left_d = point_left;
               state_d       = StPoint;
            end else if (tick_en) begin
               if (ball_dir_x) begin
                  if (ball_x_q < MaxX) ball_x_d = ball_x_q + 10'd1;
               end else if (ball_x_q != '0) begin
                  ball_x_d = ball_x_q - 10'd1;
               end
               if (ball_dir_y) begin
                  if (ball_y_q < MaxY) ball_y_d = ball_y_q + 10'd1;
               end else if (ball_y_q != '0) begin
                  ball_y_d = ball_y_q - 10'd1;
               end
            end
         end
         StPoint: begin
            inc_left  = scorer_left_q;
            inc_right = ~scorer_left_q;
            state_d   = StServe;
            if (scorer_left_q ? (score_left == WinM1 || left_at_max)
                              : (score_right == WinM1 || right_at_max)) begin
               state_d  = StOver;
               winner_d = scorer_left_q;
            end
         end
         StOver: begin
            if (start) begin
               clr_scores = 1'b1;
               state_d    = StServe;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State, ball and bookkeeping registers with asynchronous active-high reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= StIdle;
         ball_x_q      <= StartX;
         ball_y_q      <= StartY;
         serve_cnt_q   <= '0;
         scorer_left_q <= 1'b0;
         winner_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         ball_x_q      <= ball_x_d;
         ball_y_q      <= ball_y_d;
         serve_cnt_q   <= serve_cnt_d;
         scorer_left_q <= scorer_left_d;
         winner_q      <= winner_d;
      end
   end

   assign ball_x    = ball_x_q;
   assign ball_y    = ball_y_q;
   assign playing   = (state_q == StPlay);
   assign game_over = (state_q == StOver);
   assign winner    = winner_q;

endmodule

// File: tb/tb_game_flow_controller.sv
// Self-checking bench for game_flow_controller (SERVE_FRAMES=3) with a behavioural model.
module tb_game_flow_controller;

   localparam int SF  = 3;
   localparam int WIN = 9;
   localparam int SX  = 312;
   localparam int SY  = 232;
   localparam int XMAX = 624;
   localparam int YMAX = 464;

   // Model modes (plain integers, independent of the RTL encoding)
   localparam int M_IDLE = 0, M_SERVE = 1, M_PLAY = 2, M_POINT = 3, M_OVER = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       frame_tick = 1'b0, start = 1'b0, point_left = 1'b0, point_right = 1'b0;
   logic       ball_dir_x = 1'b0, ball_dir_y = 1'b0;
   logic [9:0] ball_x, ball_y;
   logic [3:0] score_left, score_right;
   logic       game_over, winner, playing;
`ifdef PONG_PAUSE_EN
   logic       pause = 1'b0;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model
   int m_mode, m_x, m_y, m_sl, m_sr, m_ticks, m_win;
   bit m_left;

   game_flow_controller #(
      .BALL_START_X (SX),
      .BALL_START_Y (SY),
      .SERVE_FRAMES (SF),
      .WIN_SCORE    (WIN)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .frame_tick  (frame_tick),
      .start       (start),
      .point_left  (point_left),
      .point_right (point_right),
      .ball_dir_x  (ball_dir_x),
      .ball_dir_y  (ball_dir_y),
      .ball_x      (ball_x),
      .ball_y      (ball_y),
      .score_left  (score_left),
      .score_right (score_right),
      .game_over   (game_over),
      .winner      (winner),
      .playing     (playing)
`ifdef PONG_PAUSE_EN
      ,
      .pause       (pause)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL timeout: bench did not finish (actual=running required=finished)");
      $fatal(1, "timeout");
   end

   task automatic model_reset();
      m_mode = M_IDLE; m_x = SX; m_y = SY; m_sl = 0; m_sr = 0; m_ticks = 0; m_win = 0;
      m_left = 1'b0;
   endtask

   // Game rules applied to one clock cycle's inputs.
   task automatic model_next(input bit tk, st, pl, pr, dx, dy);
      int nm;
      nm = m_mode;
      case (m_mode)
         M_IDLE: if (st) begin nm = M_SERVE; m_ticks = 0; end
         M_SERVE: if (tk) begin
            m_ticks = m_ticks + 1;
            if (m_ticks == SF) nm = M_PLAY;
         end
         M_PLAY: begin
            if (pl || pr) begin
               m_left = pl;
               nm = M_POINT;
            end else if (tk) begin
               if (dx) m_x = (m_x + 1 > XMAX) ? m_x : m_x + 1;
               else    m_x = (m_x == 0) ? 0 : m_x - 1;
               if (dy) m_y = (m_y + 1 > YMAX) ? m_y : m_y + 1;
               else    m_y = (m_y == 0) ? 0 : m_y - 1;
            end
         end
         M_POINT: begin
            if (m_left) m_sl = (m_sl + 1 > WIN) ? WIN : m_sl + 1;
            else        m_sr = (m_sr + 1 > WIN) ? WIN : m_sr + 1;
            m_x = SX; m_y = SY; m_ticks = 0;
            if ((m_left ? m_sl : m_sr) == WIN) begin
               nm = M_OVER;
               m_win = m_left ? 1 : 0;
            end else begin
               nm = M_SERVE;
            end
         end
         M_OVER: if (st) begin m_sl = 0; m_sr = 0; m_ticks = 0; nm = M_SERVE; end
         default: nm = M_IDLE;
      endcase
      m_mode = nm;
   endtask

   // Apply inputs for one cycle, advance the model, land 1 time unit after the edge.
   task automatic step(input bit tk, st, pl, pr, dx, dy);
      frame_tick = tk; start = st; point_left = pl; point_right = pr;
      ball_dir_x = dx; ball_dir_y = dy;
      model_next(tk, st, pl, pr, dx, dy);
      @(posedge clk);
      #1;
      frame_tick = 1'b0; start = 1'b0; point_left = 1'b0; point_right = 1'b0;
   endtask

   // From IDLE or OVER: press start and serve through SF ticks.
   task automatic go_play();
      step(0, 1, 0, 0, 0, 0);
      for (int i = 0; i < SF; i++) step(1, 0, 0, 0, 0, 0);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({ball_x, ball_y, score_left, score_right, game_over, winner, playing} !==
          {10'(SX), 10'(SY), 4'd0, 4'd0, 1'b0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_state: got x=%0d y=%0d sl=%0d sr=%0d go=%b w=%b pl=%b, want 312 232 0 0 0 0 0",
                  ball_x, ball_y, score_left, score_right, game_over, winner, playing);
      end
      reset = 1'b0;
      step(1, 0, 0, 0, 1, 1);
      n_checks++;
      if (playing !== 1'b0 || ball_x !== 10'(SX)) begin
         n_fail++;
         $display("FAIL idle_hold: got playing=%b x=%0d, want 0 312", playing, ball_x);
      end
   endtask

   task automatic test_serve();
      step(0, 1, 0, 0, 0, 0);
      for (int i = 0; i < SF; i++) begin
         n_checks++;
         if (playing !== 1'b0) begin
            n_fail++;
            $display("FAIL serve_early: tick %0d got playing=%b want 0", i, playing);
         end
         step(1, 0, 0, 0, 1, 1);
      end
      n_checks++;
      if ({playing, ball_x, ball_y} !== {1'b1, 10'd312, 10'd232}) begin
         n_fail++;
         $display("FAIL serve_to_play: got playing=%b x=%0d y=%0d want 1 312 232",
                  playing, ball_x, ball_y);
      end
   endtask

   task automatic test_move();
      for (int i = 0; i < 5; i++) begin
         step(1, 0, 0, 0, 1, 0);
         step(0, 0, 0, 0, 0, 1);
      end
      n_checks++;
      if (ball_x !== 10'd317 || ball_y !== 10'd227) begin
         n_fail++;
         $display("FAIL move5: got (%0d,%0d) want (317,227)", ball_x, ball_y);
      end
      // start is ignored in PLAY
      step(0, 1, 0, 0, 0, 0);
      n_checks++;
      if (playing !== 1'b1 || ball_x !== 10'd317) begin
         n_fail++;
         $display("FAIL start_in_play: got playing=%b x=%0d want 1 317", playing, ball_x);
      end
   endtask

   task automatic test_clamp();
      bit dy;
      dy = 1'b1;
      for (int i = 0; i < 307; i++) begin
         step(1, 0, 0, 0, 1, dy);
         dy = ~dy;
      end
      n_checks++;
      if (ball_x !== 10'd624 || ball_y !== 10'(m_y)) begin
         n_fail++;
         $display("FAIL reach_xmax: got (%0d,%0d) want (624,%0d)", ball_x, ball_y, m_y);
      end
      step(1, 0, 0, 0, 1, 1);
      n_checks++;
      if (ball_x !== 10'd624 || ball_y !== 10'(m_y)) begin
         n_fail++;
         $display("FAIL clamp_xmax: got (%0d,%0d) want (624,%0d)", ball_x, ball_y, m_y);
      end
      for (int i = 0; i < 240; i++) step(1, 0, 0, 0, 0, 0);
      n_checks++;
      if (ball_y !== 10'd0 || ball_x !== 10'(m_x)) begin
         n_fail++;
         $display("FAIL clamp_ymin: got (%0d,%0d) want (%0d,0)", ball_x, ball_y, m_x);
      end
   endtask

   task automatic test_point_tick();
      int px, py;
      px = m_x; py = m_y;
      step(1, 0, 1, 0, 1, 1);
      n_checks++;
      if (ball_x !== 10'(px) || ball_y !== 10'(py) || playing !== 1'b0) begin
         n_fail++;
         $display("FAIL point_no_move: got (%0d,%0d) playing=%b want (%0d,%0d) 0",
                  ball_x, ball_y, playing, px, py);
      end
      step(0, 0, 0, 0, 0, 0);
      n_checks++;
      if ({score_left, score_right, ball_x, ball_y, game_over, playing} !==
          {4'd1, 4'd0, 10'd312, 10'd232, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL point_left: got sl=%0d sr=%0d (%0d,%0d) go=%b pl=%b want 1 0 (312,232) 0 0",
                  score_left, score_right, ball_x, ball_y, game_over, playing);
      end
      // Point pulses in SERVE are ignored
      step(0, 0, 1, 1, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      n_checks++;
      if (score_left !== 4'd1 || score_right !== 4'd0) begin
         n_fail++;
         $display("FAIL point_in_serve: got sl=%0d sr=%0d want 1 0", score_left, score_right);
      end
      for (int i = 0; i < SF; i++) step(1, 0, 0, 0, 0, 0);
      n_checks++;
      if (playing !== 1'b1) begin
         n_fail++;
         $display("FAIL reserve: got playing=%b want 1", playing);
      end
      // Both pulses in one cycle count for the left player
      step(0, 0, 1, 1, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      n_checks++;
      if (score_left !== 4'd2 || score_right !== 4'd0) begin
         n_fail++;
         $display("FAIL both_points: got sl=%0d sr=%0d want 2 0", score_left, score_right);
      end
   endtask

   task automatic test_win();
      for (int p = 0; p < 8; p++) begin
         for (int i = 0; i < SF; i++) step(1, 0, 0, 0, 0, 0);
         step(0, 0, 0, 1, 0, 0);
         step(0, 0, 0, 0, 0, 0);
      end
      n_checks++;
      if (score_right !== 4'd8 || game_over !== 1'b0) begin
         n_fail++;
         $display("FAIL right_eight: got sr=%0d go=%b want 8 0", score_right, game_over);
      end
      for (int i = 0; i < SF; i++) step(1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      n_checks++;
      if ({score_right, score_left, game_over, winner, playing} !==
          {4'd9, 4'd2, 1'b1, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL right_wins: got sr=%0d sl=%0d go=%b w=%b pl=%b want 9 2 1 0 0",
                  score_right, score_left, game_over, winner, playing);
      end
      // OVER freezes everything against ticks and point pulses
      step(1, 0, 1, 1, 1, 1);
      n_checks++;
      if ({score_right, score_left, game_over, winner, ball_x} !==
          {4'd9, 4'd2, 1'b1, 1'b0, 10'd312}) begin
         n_fail++;
         $display("FAIL over_frozen: got sr=%0d sl=%0d go=%b w=%b x=%0d want 9 2 1 0 312",
                  score_right, score_left, game_over, winner, ball_x);
      end
      step(0, 1, 0, 0, 0, 0);
      n_checks++;
      if ({score_left, score_right, game_over, playing} !== {4'd0, 4'd0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL restart: got sl=%0d sr=%0d go=%b pl=%b want 0 0 0 0",
                  score_left, score_right, game_over, playing);
      end
      for (int i = 0; i < SF; i++) step(1, 0, 0, 0, 0, 0);
      n_checks++;
      if (playing !== 1'b1) begin
         n_fail++;
         $display("FAIL restart_serve: got playing=%b want 1", playing);
      end
   endtask

   task automatic test_async_reset();
      step(0, 0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < SF; i++) step(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 1, 1);
      n_checks++;
      if (score_left !== 4'd1 || playing !== 1'b1 || ball_x !== 10'd316) begin
         n_fail++;
         $display("FAIL pre_reset: got sl=%0d pl=%b x=%0d want 1 1 316",
                  score_left, playing, ball_x);
      end
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if ({score_left, score_right, ball_x, ball_y, playing, game_over, winner} !==
          {4'd0, 4'd0, 10'd312, 10'd232, 1'b0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL async_reset: got sl=%0d sr=%0d (%0d,%0d) pl=%b go=%b w=%b want 0 0 (312,232) 0 0 0",
                  score_left, score_right, ball_x, ball_y, playing, game_over, winner);
      end
      model_reset();
      @(posedge clk);
      #1 reset = 1'b0;
      // Back in IDLE: ticks alone do not start a serve
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      n_checks++;
      if (playing !== 1'b0 || game_over !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_after_reset: got pl=%b go=%b want 0 0", playing, game_over);
      end
   endtask

   task automatic test_random();
      bit tk, st, pl, pr, dx, dy;
      for (int c = 0; c < 1500; c++) begin
         tk = ($urandom_range(0, 1) == 0);
         st = ($urandom_range(0, 7) == 0);
         pl = ($urandom_range(0, 9) == 0);
         pr = ($urandom_range(0, 9) == 0);
         dx = $urandom_range(0, 1);
         dy = $urandom_range(0, 1);
         step(tk, st, pl, pr, dx, dy);
         n_checks++;
         if ({ball_x, ball_y, score_left, score_right, playing, game_over} !==
             {10'(m_x), 10'(m_y), 4'(m_sl), 4'(m_sr), m_mode == M_PLAY, m_mode == M_OVER} ||
             (m_mode == M_OVER && winner !== 1'(m_win))) begin
            n_fail++;
            $display("FAIL random_cycle_%0d: got (%0d,%0d) sl=%0d sr=%0d pl=%b go=%b w=%b want (%0d,%0d) sl=%0d sr=%0d pl=%0d go=%0d w=%0d",
                     c, ball_x, ball_y, score_left, score_right, playing, game_over, winner,
                     m_x, m_y, m_sl, m_sr, m_mode == M_PLAY, m_mode == M_OVER, m_win);
         end
      end
   endtask

   initial begin
      test_reset();
      test_serve();
      test_move();
      test_clamp();
      test_point_tick();
      test_win();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
